paddle_hit_detector: RTL and testbench

Upstream neighbour of the ball game controller. Builds a per-frame bounding box of the camera-detected paddle from the colour-mask pixel stream and estimates the paddle's vertical speed from frame-to-frame centroid motion. It compares the ball box against the latched paddle box and issues a one-cycle `collision_detected` pulse plus `estimated_speed` to the controller, with a frame-based cooldown against repeat hits.

---
 rtl/paddle_hit_detector.sv | 193 +++++++++++++++++++
 tb/tb_paddle_hit_detector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/paddle_hit_detector.sv
// paddle_hit_detector: builds a per-frame paddle bounding box from the camera
// colour mask, estimates the paddle's vertical speed, and pulses a collision
// when the ball box overlaps the latched paddle box while moving toward the
// player. Repeat hits are suppressed for a number of frames after each pulse.
module paddle_hit_detector #(
   parameter int MIN_PIXELS      = 64,
   parameter int BALL_SIZE       = 20,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic       clk_25MHZ,
   input  logic       reset,
   input  logic       upscale,
   input  logic       de,
   input  logic [9:0] x_pixel,
   input  logic [9:0] y_pixel,
   input  logic       paddle_pixel,
   input  logic       frame_tick,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   input  logic       is_ball_moving_left,
   output logic       collision_detected,
   output logic [9:0] estimated_speed,
   output logic       paddle_valid,
   output logic [9:0] paddle_x_min,
   output logic [9:0] paddle_x_max,
   output logic [9:0] paddle_y_min,
   output logic [9:0] paddle_y_max
);

   localparam int CDW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HIT, S_COOL} state_t;

   state_t           state_q, state_d;
   logic [CDW-1:0]   cd_q, cd_d;
   logic [9:0]       axmin_q, axmin_d, axmax_q, axmax_d;
   logic [9:0]       aymin_q, aymin_d, aymax_q, aymax_d;
   logic [18:0]      cnt_q, cnt_d;
   logic [9:0]       bxmin_q, bxmin_d, bxmax_q, bxmax_d;
   logic [9:0]       bymin_q, bymin_d, bymax_q, bymax_d;
   logic             valid_q, valid_d;
   logic [9:0]       speed_q, speed_d;
   logic [9:0]       cy_prev_q, cy_prev_d;
   logic             coll_q;

   // Camera coordinates mapped into game space before accumulation.
   logic [9:0] px, py;
   assign px = upscale ? x_pixel : {1'b0, x_pixel[9:1]};
   assign py = upscale ? y_pixel : {1'b0, y_pixel[9:1]};

   // The pixel coinciding with frame_tick is deliberately dropped.
   logic acc_en;
   assign acc_en = de && paddle_pixel && !frame_tick;

   // Centroid of the box currently being accumulated (latched on frame_tick).
   logic [10:0] ysum;
   logic [9:0]  cy_new;
   assign ysum   = {1'b0, aymin_q} + {1'b0, aymax_q};
   assign cy_new = ysum[10:1];

   // Overlap uses only latched box values; 11-bit math keeps the ball's far edge from wrapping.
   logic [10:0] ball_x_far, ball_y_far;
   logic        overlap;
   assign ball_x_far = {1'b0, ball_x} + 11'(BALL_SIZE) - 11'd1;
   assign ball_y_far = {1'b0, ball_y} + 11'(BALL_SIZE) - 11'd1;
   assign overlap = ({1'b0, ball_x} <= {1'b0, bxmax_q}) && (ball_x_far >= {1'b0, bxmin_q}) &&
                    ({1'b0, ball_y} <= {1'b0, bymax_q}) && (ball_y_far >= {1'b0, bymin_q});

   // Running box accumulation; restarts on every frame_tick.
   always_comb begin
      axmin_d = axmin_q;
      axmax_d = axmax_q;
      aymin_d = aymin_q;
      aymax_d = aymax_q;
      cnt_d   = cnt_q;
      if (frame_tick) begin
         axmin_d = 10'd1023;
         axmax_d = 10'd0;
         aymin_d = 10'd1023;
         aymax_d = 10'd0;
         cnt_d   = 19'd0;
      end else if (acc_en) begin
         if (px < axmin_q) axmin_d = px;
         if (px > axmax_q) axmax_d = px;
         if (py < aymin_q) aymin_d = py;
         if (py > aymax_q) aymax_d = py;
         cnt_d = cnt_q + 19'd1;
      end
   end

   // Frame latch: box, validity and speed change only on frame_tick, which
   // also keeps the speed stable from a hit until the next frame boundary.
   always_comb begin
      bxmin_d   = bxmin_q;
      bxmax_d   = bxmax_q;
      bymin_d   = bymin_q;
      bymax_d   = bymax_q;
      valid_d   = valid_q;
      speed_d   = speed_q;
      cy_prev_d = cy_prev_q;
      if (frame_tick) begin
         if (cnt_q >= 19'(MIN_PIXELS)) begin
            bxmin_d   = axmin_q;
            bxmax_d   = axmax_q;
            bymin_d   = aymin_q;
            bymax_d   = aymax_q;
            valid_d   = 1'b1;
            cy_prev_d = cy_new;
            if (valid_q)
               speed_d = (cy_new >= cy_prev_q) ? (cy_new - cy_prev_q) : (cy_prev_q - cy_new);
            else
               speed_d = 10'd0;
         end else begin
            valid_d = 1'b0;
            speed_d = 10'd0;
         end
      end
   end

   // Hit FSM: HIT always reloads the cooldown, so a coincident frame_tick is not counted.
   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      case (state_q)
         S_IDLE:  if (valid_q) state_d = S_ARMED;
         S_ARMED: begin
            if (overlap && is_ball_moving_left && valid_q) state_d = S_HIT;
            else if (!valid_q)                           state_d = S_IDLE;
         end
         S_HIT: begin
            cd_d    = CDW'(COOLDOWN_FRAMES);
            state_d = S_COOL;
         end
         S_COOL: begin
            if (frame_tick) begin
               if (cd_q <= CDW'(1)) begin
                  cd_d    = '0;
                  state_d = valid_q ? S_ARMED : S_IDLE;
               end else begin
                  cd_d = cd_q - CDW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset discards any partial frame.
   always_ff @(posedge clk_25MHZ) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cd_q      <= '0;
         axmin_q   <= 10'd1023;
         axmax_q   <= 10'd0;
         aymin_q   <= 10'd1023;
         aymax_q   <= 10'd0;
         cnt_q     <= 19'd0;
         bxmin_q   <= 10'd0;
         bxmax_q   <= 10'd0;
         bymin_q   <= 10'd0;
         bymax_q   <= 10'd0;
         valid_q   <= 1'b0;
         speed_q   <= 10'd0;
         cy_prev_q <= 10'd0;
         coll_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cd_q      <= cd_d;
         axmin_q   <= axmin_d;
         axmax_q   <= axmax_d;
         aymin_q   <= aymin_d;
         aymax_q   <= aymax_d;
         cnt_q     <= cnt_d;
         bxmin_q   <= bxmin_d;
         bxmax_q   <= bxmax_d;
         bymin_q   <= bymin_d;
         bymax_q   <= bymax_d;
         valid_q   <= valid_d;
         speed_q   <= speed_d;
         cy_prev_q <= cy_prev_d;
         coll_q    <= (state_q == S_HIT);
      end
   end

   assign collision_detected = coll_q;
   assign estimated_speed    = speed_q;
   assign paddle_valid       = valid_q;
   assign paddle_x_min       = bxmin_q;
   assign paddle_x_max       = bxmax_q;
   assign paddle_y_min       = bymin_q;
   assign paddle_y_max       = bymax_q;

endmodule

// File: tb/tb_paddle_hit_detector.sv
// Directed bench for paddle_hit_detector: box latch, speed, hit pulse timing,
// cooldown, invalid frames and mid-frame reset.
module tb_paddle_hit_detector;

   logic       clk_25MHZ = 1'b0;
   logic       reset = 1'b0;
   logic       upscale = 1'b1;
   logic       de = 1'b0;
   logic [9:0] x_pixel = '0, y_pixel = '0;
   logic       paddle_pixel = 1'b0;
   logic       frame_tick = 1'b0;
   logic [9:0] ball_x = '0, ball_y = '0;
   logic       is_ball_moving_left = 1'b0;
   logic       collision_detected;
   logic [9:0] estimated_speed;
   logic       paddle_valid;
   logic [9:0] paddle_x_min, paddle_x_max, paddle_y_min, paddle_y_max;

   int n_chk = 0;
   int n_pass = 0;
   int pulses = 0;
   int wide = 0;
   logic coll_prev = 1'b0;
   int base;

   paddle_hit_detector #(.MIN_PIXELS(64), .BALL_SIZE(20), .COOLDOWN_FRAMES(8)) dut (
      .clk_25MHZ(clk_25MHZ), .reset(reset), .upscale(upscale), .de(de),
      .x_pixel(x_pixel), .y_pixel(y_pixel), .paddle_pixel(paddle_pixel),
      .frame_tick(frame_tick), .ball_x(ball_x), .ball_y(ball_y),
      .is_ball_moving_left(is_ball_moving_left),
      .collision_detected(collision_detected), .estimated_speed(estimated_speed),
      .paddle_valid(paddle_valid), .paddle_x_min(paddle_x_min), .paddle_x_max(paddle_x_max),
      .paddle_y_min(paddle_y_min), .paddle_y_max(paddle_y_max));

   always #20 clk_25MHZ = ~clk_25MHZ;

   // Pulse monitor sampled mid-cycle: counts pulses and flags any pulse wider than one cycle.
   always @(negedge clk_25MHZ) begin
      if (collision_detected) pulses++;
      if (collision_detected && coll_prev) wide++;
      coll_prev = collision_detected;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk_25MHZ);
      #1;
   endtask

   task automatic send_block(input int x0, input int x1, input int y0, input int y1, input int lim);
      int n = 0;
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            if (n < lim) begin
               de = 1'b1; paddle_pixel = 1'b1;
               x_pixel = 10'(x); y_pixel = 10'(y);
               step();
               n++;
            end
      de = 1'b0; paddle_pixel = 1'b0;
   endtask

   // frame_tick with a stray masked pixel far outside every block; it must be ignored.
   task automatic tick();
      frame_tick = 1'b1;
      de = 1'b1; paddle_pixel = 1'b1; x_pixel = 10'd600; y_pixel = 10'd10;
      step();
      frame_tick = 1'b0; de = 1'b0; paddle_pixel = 1'b0;
   endtask

   task automatic chk_box(input string tag, input int x0, input int x1, input int y0, input int y1);
      chk({tag, "_xmin"}, int'(paddle_x_min), x0);
      chk({tag, "_xmax"}, int'(paddle_x_max), x1);
      chk({tag, "_ymin"}, int'(paddle_y_min), y0);
      chk({tag, "_ymax"}, int'(paddle_y_max), y1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      // Reset state
      reset = 1'b0;
      step(); step();
      reset = 1'b1;
      chk("rst_coll", int'(collision_detected), 0);
      chk("rst_speed", int'(estimated_speed), 0);
      chk("rst_valid", int'(paddle_valid), 0);
      chk_box("rst", 0, 0, 0, 0);

      // Valid box, then movement of 30 rows in game space
      send_block(20, 59, 200, 299, 100000);
      tick();
      chk_box("frA", 20, 59, 200, 299);
      chk("frA_valid", int'(paddle_valid), 1);
      chk("frA_speed", int'(estimated_speed), 0);
      send_block(20, 59, 230, 329, 100000);
      tick();
      chk_box("frB", 20, 59, 230, 329);
      chk("frB_speed", int'(estimated_speed), 30);

      // Overlapping ball moving away: no pulse
      ball_x = 10'd50; ball_y = 10'd250; is_ball_moving_left = 1'b0;
      base = pulses;
      repeat (5) step();
      chk("noleft_pulses", pulses - base, 0);

      // Moving left: pulse 2 edges after the inputs, exactly one cycle
      is_ball_moving_left = 1'b1;
      step(); chk("hit_e1", int'(collision_detected), 0);
      step(); chk("hit_e2", int'(collision_detected), 1);
      step(); chk("hit_e3", int'(collision_detected), 0);

      // Cooldown: 10 overlapping frames, second pulse only after the 8th tick
      base = pulses;
      for (int f = 1; f <= 10; f++) begin
         send_block(50, 57, 250, 257, 100000);
         if (f == 9) begin
            chk("cd_pulse_after8", pulses - base, 1);
            chk("cd_speed_hold", int'(estimated_speed), 0);
         end
         tick();
         if (f == 1) chk("cd_speed1", int'(estimated_speed), 26);
         if (f <= 7) chk($sformatf("cd_nopulse%0d", f), pulses - base, 0);
      end
      repeat (4) step();
      chk("cd_total", pulses - base, 1);
      chk("pulse_width", wide, 0);

      // upscale=0: halved coordinates and speed
      is_ball_moving_left = 1'b0; ball_x = 10'd0; ball_y = 10'd0;
      do_reset();
      upscale = 1'b0;
      send_block(20, 59, 200, 299, 100000);
      tick();
      chk_box("up0A", 10, 29, 100, 149);
      send_block(20, 59, 230, 329, 100000);
      tick();
      chk_box("up0B", 10, 29, 115, 164);
      chk("up0_speed", int'(estimated_speed), 15);

      // Invalid frame: 63 pixels
      upscale = 1'b1;
      do_reset();
      ball_x = 10'd50; ball_y = 10'd250; is_ball_moving_left = 1'b0;
      send_block(50, 57, 250, 257, 64);
      tick();
      chk("inv_pre_valid", int'(paddle_valid), 1);
      send_block(300, 307, 100, 107, 63);
      tick();
      chk("inv_valid", int'(paddle_valid), 0);
      chk("inv_speed", int'(estimated_speed), 0);
      chk_box("inv", 50, 57, 250, 257);
      base = pulses;
      is_ball_moving_left = 1'b1;
      repeat (10) step();
      chk("inv_nopulse", pulses - base, 0);

      // Reset mid-frame discards the partial frame
      is_ball_moving_left = 1'b0;
      send_block(100, 107, 100, 107, 32);
      do_reset();
      chk("mrst_coll", int'(collision_detected), 0);
      chk("mrst_speed", int'(estimated_speed), 0);
      chk("mrst_valid", int'(paddle_valid), 0);
      chk_box("mrst", 0, 0, 0, 0);
      send_block(200, 207, 300, 307, 64);
      tick();
      chk("mrst_valid2", int'(paddle_valid), 1);
      chk_box("mrst2", 200, 207, 300, 307);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
